regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (reg_write / write_reg / write_data) between two writeback requesters: ALU and load/memory unit.
- Round-robin grant with valid/ready handshake; one registered write per cycle into the register file.
- Keeps a pending-write scoreboard (one bit per architectural register) so issue logic can stall on outstanding producers.
- Sits between the execute/memory stages and the registers block.

Parameters:
- DATA_WIDTH, 32, width of write data
- ADDR_WIDTH, 5, register index width; register count = 2**ADDR_WIDTH

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- mem_valid  in  1  memory writeback request
- mem_rd  in  ADDR_WIDTH  memory destination register
- mem_data  in  DATA_WIDTH  load result
- mem_ready  out  1  memory request accepted this cycle
- issue_valid  in  1  instruction issued with a register destination
- issue_rd  in  ADDR_WIDTH  destination of the issued instruction
- reg_write  out  1  register file write enable
- write_reg  out  ADDR_WIDTH  register file write index
- write_data  out  DATA_WIDTH  register file write data
- pending  out  2**ADDR_WIDTH  scoreboard, bit n = write to xn outstanding

Behaviour:
- Reset (asynchronous, immediate): reg_write=0, write_reg=0, write_data=0, pending=0, round-robin pointer = "ALU next".
- Grant (combinational, same cycle):
  - Only one valid: that requester is granted.
  - Both valid: requester at the pointer is granted.
  - alu_ready / mem_ready = grant; at most one asserted; never asserted without the matching valid.
- Pointer update: on each accepted transfer, the pointer moves to the other requester. No transfer leaves the pointer unchanged.
- Requester obligation: once valid, rd and data must stay stable until ready.
- Write stage (one-cycle latency):
  - At the edge where a request is accepted, register reg_write = (rd != 0), write_reg = rd, write_data = data.
  - reg_write is high for exactly one cycle per accepted non-x0 request.
  - No acceptance: reg_write=0; write_reg and write_data hold their previous values.
- x0 handling: a request with rd=0 is still accepted (ready=1) but is dropped. Never set pending[0].
- Scoreboard:
  - issue_valid with issue_rd != 0 sets pending[issue_rd] at the clock edge.
  - Acceptance of a request with rd = n clears pending[n] at the acceptance edge, the same edge that registers the write.
  - Set and clear of the same index in one cycle: set wins (a newer producer is outstanding).
  - Writes to registers that are not pending are still performed; pending is unaffected.
- Reset mid-operation: any in-flight registered write is discarded (reg_write forced 0) and the scoreboard is cleared.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate ALU, MEM, ALU, ...

Optional Feature:
- Macro: REGFILE_WRITE_ARB_FIXED_PRIO_EN
- Defined: fixed priority, MEM always wins over ALU when both are valid; the pointer is removed.
- Undefined: round-robin as specified above.

Decomposition:
- Package regfile_pkg:
  - DATA_WIDTH and ADDR_WIDTH defaults
  - NUM_REGS = 2**ADDR_WIDTH
  - requester ID constants REQ_ALU=0, REQ_MEM=1
- Sub-module rr_arbiter2: two-input round-robin arbiter holding the pointer. Inputs: clk, reset, req[1:0], advance. Output: gnt[1:0]. The fixed-priority macro is handled inside it.
- Scoreboard and write-stage registers stay in the top module.

Test Plan:
- Reset applied mid-stream with alu_valid=1, alu_rd=5 → next cycle reg_write=0, pending=0. After release, the first simultaneous request grants ALU.
- alu_valid=1, alu_rd=10, alu_data=100 only → alu_ready=1 the same cycle. Next cycle reg_write=1, write_reg=10, write_data=100. Following cycle reg_write=0.
- Both valid for 4 cycles (ALU x13=56, MEM x17=78, requests held until accepted) → grants ALU, MEM, ALU, MEM. reg_write stays high; write_reg sequence 13, 17, 13, 17.
- Both valid with REGFILE_WRITE_ARB_FIXED_PRIO_EN defined → mem_ready=1 and alu_ready=0 every cycle while mem_valid stays high.
- mem_valid=1, mem_rd=0, mem_data=10 → mem_ready=1, reg_write stays 0, pending[0] stays 0.
- issue_valid=1, issue_rd=23 → pending[23]=1. Later alu_rd=23 accepted in the same cycle as issue_valid, issue_rd=23 → pending[23] remains 1. A later accept of rd=23 with no issue clears it to 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write arbiter.
package regfile_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int NUM_REGS       = 2 ** DEF_ADDR_WIDTH;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_MEM = 1'b1
    } rr_ptr_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request, issue and register-file write bundle for the write arbiter.
interface regfile_write_arbiter_if
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic                  alu_valid;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_ready;

    logic                  mem_valid;
    logic [ADDR_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_ready;

    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;

    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] write_reg;
    logic [DATA_WIDTH-1:0] write_data;
    logic [NREGS-1:0]      pending;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output issue_valid, issue_rd,
        input  reg_write, write_reg, write_data, pending
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  issue_valid, issue_rd,
        output reg_write, write_reg, write_data, pending
    );

endinterface

// File: rtl/regfile_write_arbiter_rr.sv
// Two-input arbiter: round-robin by default, MEM-over-ALU fixed priority
// when REGFILE_WRITE_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef REGFILE_WRITE_ARB_FIXED_PRIO_EN
    logic unused_ok;
    assign unused_ok = clk ^ reset ^ advance;

    always_comb begin
        gnt = '0;
        if (req[REQ_MEM]) begin
            gnt[REQ_MEM] = 1'b1;
        end else if (req[REQ_ALU]) begin
            gnt[REQ_ALU] = 1'b1;
        end
    end
`else
    rr_ptr_t ptr_q, ptr_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= PTR_ALU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        if (req[REQ_ALU] && (!req[REQ_MEM] || ptr_q == PTR_ALU)) begin
            gnt[REQ_ALU] = 1'b1;
        end else if (req[REQ_MEM]) begin
            gnt[REQ_MEM] = 1'b1;
        end
        // After a transfer the requester that just lost priority is favoured.
        if (advance && (|gnt)) begin
            ptr_d = gnt[REQ_ALU] ? PTR_MEM : PTR_ALU;
        end
    end
`endif

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and MEM writebacks and
// tracks outstanding producers. Option: REGFILE_WRITE_ARB_FIXED_PRIO_EN.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
)(
    input  logic                      clk,
    input  logic                      reset,
    regfile_write_arbiter_if.slave    bus
);
    localparam int NREGS = 2 ** ADDR_WIDTH;

    logic [1:0]            req;
    logic [1:0]            gnt;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  reg_write_q, reg_write_d;
    logic [ADDR_WIDTH-1:0] write_reg_q, write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [NREGS-1:0]      pending_q, pending_d;

    assign req[REQ_ALU] = bus.alu_valid;
    assign req[REQ_MEM] = bus.mem_valid;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    assign bus.alu_ready = gnt[REQ_ALU];
    assign bus.mem_ready = gnt[REQ_MEM];
    assign accept        = |gnt;
    assign sel_rd        = gnt[REQ_MEM] ? bus.mem_rd   : bus.alu_rd;
    assign sel_data      = gnt[REQ_MEM] ? bus.mem_data : bus.alu_data;

    always_comb begin
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        pending_d    = pending_q;
        if (accept) begin
            // x0 requests are consumed but never reach the register file.
            reg_write_d  = (sel_rd != '0);
            write_reg_d  = sel_rd;
            write_data_d = sel_data;
            pending_d[sel_rd] = 1'b0;
        end
        // A same-cycle issue marks a newer producer, so the set wins.
        if (bus.issue_valid && bus.issue_rd != '0) begin
            pending_d[bus.issue_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            pending_q    <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            pending_q    <= pending_d;
        end
    end

    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.pending    = pending_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised scoreboard bench for regfile_write_arbiter with a behavioural model.
module tb_regfile_write_arbiter;

    logic clk;
    logic reset;

    regfile_write_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    regfile_write_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          ar;
        bit          mr;
        bit          rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [31:0] pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    // Behavioural model state
    bit          m_mem_next = 0;   // 1: MEM wins the next tie
    bit          m_rw = 0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_pend = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Drives one cycle of stimulus and records what the DUT must do.
    task automatic drive(input bit rst, input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                         input bit iv, input logic [4:0] ird,
                         output bit ga, output bit gm);
        exp_t e;
        @(negedge clk);
        reset           = rst;
        bus.alu_valid   = av;  bus.alu_rd = ard; bus.alu_data = ad;
        bus.mem_valid   = mv;  bus.mem_rd = mrd; bus.mem_data = md;
        bus.issue_valid = iv;  bus.issue_rd = ird;
        if (rst) m_mem_next = 0;
`ifdef REGFILE_WRITE_ARB_FIXED_PRIO_EN
        gm = mv;
        ga = av && !mv;
`else
        if (av && mv) begin
            ga = !m_mem_next;
            gm = m_mem_next;
        end else begin
            ga = av;
            gm = mv;
        end
`endif
        e.ar = ga;
        e.mr = gm;
        if (rst) begin
            m_rw = 0; m_wr = '0; m_wd = '0; m_pend = '0;
        end else begin
            m_rw = 0;
            if (ga || gm) begin
                m_wr = ga ? ard : mrd;
                m_wd = ga ? ad : md;
                m_rw = (m_wr != 0);
                m_pend[m_wr] = 1'b0;
                m_mem_next = ga;
            end
            if (iv && ird != 0) m_pend[ird] = 1'b1;
            m_pend[0] = 1'b0;
        end
        e.rw = m_rw; e.wr = m_wr; e.wd = m_wd; e.pend = m_pend;
        exp_q.push_back(e);
    endtask

    // Monitor: samples grants before the edge and registered outputs after it.
    initial begin
        bit sa, sm;
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #2;
            sa = bus.alu_ready;
            sm = bus.mem_ready;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("alu_ready", {31'd0, sa}, {31'd0, e.ar});
                check("mem_ready", {31'd0, sm}, {31'd0, e.mr});
                check("reg_write", {31'd0, bus.reg_write}, {31'd0, e.rw});
                check("write_reg", {27'd0, bus.write_reg}, {27'd0, e.wr});
                check("write_data", bus.write_data, e.wd);
                check("pending", bus.pending, e.pend);
            end
        end
    end

    initial begin
        bit ga, gm;
        bit a_v, m_v;
        logic [4:0]  a_rd, m_rd, i_rd;
        logic [31:0] a_d, m_d;
        bit i_v, rst;
        logic [4:0] rd_pool [6];

        rd_pool[0] = 5'd0;  rd_pool[1] = 5'd5;  rd_pool[2] = 5'd10;
        rd_pool[3] = 5'd13; rd_pool[4] = 5'd23; rd_pool[5] = 5'd31;

        reset = 1'b1;
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
        bus.issue_valid = 0; bus.issue_rd = '0;
        #1;
        check("reset reg_write", {31'd0, bus.reg_write}, 32'd0);
        check("reset write_reg", {27'd0, bus.write_reg}, 32'd0);
        check("reset write_data", bus.write_data, 32'd0);
        check("reset pending", bus.pending, 32'd0);

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        // Single ALU write
        drive(0, 1, 10, 100, 0, 0, 0, 0, 0, ga, gm);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        // Both valid: alternating grants, each requester held until accepted
        a_v = 1; m_v = 1;
        for (int i = 0; i < 4; i++) begin
            drive(0, a_v, 13, 56, m_v, 17, 78, 0, 0, ga, gm);
            if (ga) a_v = 1;
            if (gm) m_v = 1;
        end
        // x0 write from MEM is accepted and dropped
        drive(0, 0, 0, 0, 1, 0, 10, 0, 0, ga, gm);
        // Scoreboard: set, set-wins collision, later clear
        drive(0, 0, 0, 0, 0, 0, 0, 1, 23, ga, gm);
        drive(0, 1, 23, 7, 0, 0, 0, 1, 23, ga, gm);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);
        drive(0, 1, 23, 8, 0, 0, 0, 0, 0, ga, gm);
        // Reset mid-stream with ALU valid, then simultaneous request
        drive(0, 0, 0, 0, 0, 0, 0, 1, 5, ga, gm);
        drive(0, 1, 9, 3, 1, 11, 4, 0, 0, ga, gm);
        drive(1, 1, 5, 55, 0, 0, 0, 0, 0, ga, gm);
        drive(0, 1, 13, 21, 1, 17, 22, 0, 0, ga, gm);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);

        // Randomised phase with held requests
        a_v = 0; m_v = 0;
        a_rd = '0; m_rd = '0; a_d = '0; m_d = '0;
        for (int c = 0; c < 400; c++) begin
            if (!a_v && $urandom_range(0, 3) != 0) begin
                a_v = 1; a_rd = rd_pool[$urandom_range(0, 5)]; a_d = $urandom;
            end
            if (!m_v && $urandom_range(0, 3) != 0) begin
                m_v = 1; m_rd = rd_pool[$urandom_range(0, 5)]; m_d = $urandom;
            end
            i_v  = ($urandom_range(0, 2) == 0);
            i_rd = rd_pool[$urandom_range(0, 5)];
            rst  = ($urandom_range(0, 60) == 0);
            drive(rst, a_v, a_rd, a_d, m_v, m_rd, m_d, i_v, i_rd, ga, gm);
            if (rst) begin
                a_v = 0; m_v = 0;
            end else begin
                if (ga) a_v = 0;
                if (gm) m_v = 0;
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, ga, gm);

        repeat (3) @(posedge clk);
        #2;
        done = 1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, 0 required", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
